// File: rtl/timekeeper_gen2.sv
// timekeeper_gen2: HH:MM:SS clock with button set mode, auto-repeat and blinking 8-digit display
module timekeeper_gen2 #(
  parameter int HOUR_MODE = 24,
  parameter int REPEAT_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_1hz,
  input  logic       pulse_500ms,
  input  logic       mode_button,
  input  logic       add_button,
  input  logic       sub_button,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8
);
  typedef enum logic [1:0] {RUN, SET_HOURS, SET_MINUTES, SET_SECONDS} state_t;
  localparam int RW = REPEAT_DELAY > 0 ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY);
  state_t state, state_n;
  logic [5:0] hours, minutes, seconds, hd;
  logic [RW-1:0] rep_cnt;
  logic mode_q, add_q, sub_q, p500_q;
  logic mode_e, p500_e, one, press, step, pm, h_en, m_en, s_en, sep_en;
  function automatic logic [5:0] wrap(input logic [5:0] v, input logic [5:0] mx, input logic up);
    return up ? (v == mx ? 6'd0 : v + 6'd1) : (v == 6'd0 ? mx : v - 6'd1);
  endfunction
  function automatic logic [5:0] digit(input logic en, input logic [5:0] v);
    return {en, 4'(v), 1'b1};
  endfunction
  always_comb begin
    mode_e = mode_button & ~mode_q;
    p500_e = pulse_500ms & ~p500_q;
    one = add_button ^ sub_button;
    press = add_button ? ~add_q : sub_button & ~sub_q;
    step = state != RUN && !mode_e && one && (press || (REPEAT_DELAY != 0 && p500_e && rep_cnt == RD));
    state_n = !mode_e ? state : state == RUN ? SET_HOURS : state == SET_HOURS ? SET_MINUTES :
              state == SET_MINUTES ? SET_SECONDS : RUN;
    hd = HOUR_MODE == 12 ? (hours == 6'd0 ? 6'd12 : hours > 6'd12 ? hours - 6'd12 : hours) : hours;
    pm = HOUR_MODE == 12 && hours >= 6'd12;
    h_en = state == SET_HOURS ? pulse_500ms : 1'b1;
    m_en = state == SET_MINUTES ? pulse_500ms : 1'b1;
    s_en = state == SET_SECONDS ? pulse_500ms : 1'b1;
    sep_en = state == RUN ? pulse_500ms : 1'b1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      hours <= '0;
      minutes <= '0;
      seconds <= '0;
      rep_cnt <= '0;
      {mode_q, add_q, sub_q, p500_q} <= '0;
      {d8, d7} <= HOUR_MODE == 12 ? {6'b100011, 6'b100101} : {6'b100001, 6'b100001};
      {d6, d3} <= {2{6'b011111}};
      {d5, d4, d2, d1} <= {4{6'b100001}};
    end else begin
      {mode_q, add_q, sub_q, p500_q} <= {mode_button, add_button, sub_button, pulse_500ms};
      state <= state_n;
      rep_cnt <= (state == RUN || mode_e || !one || REPEAT_DELAY == 0) ? '0 :
                 (p500_e && rep_cnt != RD) ? rep_cnt + RW'(1) : rep_cnt;
      if (state == RUN && pulse_1hz) begin
        seconds <= wrap(seconds, 6'd59, 1'b1);
        if (seconds == 6'd59) minutes <= wrap(minutes, 6'd59, 1'b1);
        if (seconds == 6'd59 && minutes == 6'd59) hours <= wrap(hours, 6'd23, 1'b1);
      end
      if (step && state == SET_HOURS) hours <= wrap(hours, 6'd23, add_button);
      if (step && state == SET_MINUTES) minutes <= wrap(minutes, 6'd59, add_button);
      if (step && state == SET_SECONDS) seconds <= wrap(seconds, 6'd59, add_button);
      d8 <= digit(h_en, hd / 6'd10);
      d7 <= digit(h_en, hd % 6'd10);
      d6 <= {sep_en, 4'hF, 1'b1};
      d5 <= digit(m_en, minutes / 6'd10);
      d4 <= digit(m_en, minutes % 6'd10);
      d3 <= {sep_en, 4'hF, 1'b1};
      d2 <= digit(s_en, seconds / 6'd10);
      d1 <= {s_en, 4'(seconds % 6'd10), ~pm};
    end
  end
endmodule

// File: tb/tb_timekeeper_gen2.sv
// tb_timekeeper_gen2: scoreboard bench driving a 24h and a 12h instance with shared stimulus
module tb_timekeeper_gen2;
  logic clock = 0, reset = 1;
  logic pulse_1hz = 0, pulse_500ms = 0, mode_button = 0, add_button = 0, sub_button = 0;
  logic [5:0] a1, a2, a3, a4, a5, a6, a7, a8;
  logic [5:0] b1, b2, b3, b4, b5, b6, b7, b8;
  logic [47:0] bus24, bus12, act;
  typedef struct {string name; bit s12; logic [47:0] mask; logic [47:0] val;} exp_t;
  exp_t q[$];
  exp_t cur;
  int n_cmp = 0, n_bad = 0;
  localparam logic [5:0] SP = 6'b011110;
  localparam logic [47:0] CM = {8{6'b011110}};
  localparam logic [47:0] ENM = {8{6'b100000}};
  localparam logic [47:0] R24 = {6'b100001, 6'b100001, 6'b011111, 6'b100001, 6'b100001, 6'b011111, 6'b100001, 6'b100001};
  localparam logic [47:0] R12 = {6'b100011, 6'b100101, 6'b011111, 6'b100001, 6'b100001, 6'b011111, 6'b100001, 6'b100001};
  localparam logic [47:0] FULL = '1;
  int rep_exp[4] = '{59, 59, 0, 1};

  timekeeper_gen2 #(.HOUR_MODE(24), .REPEAT_DELAY(2)) dut24 (
    .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
    .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
    .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6), .d7(a7), .d8(a8));
  timekeeper_gen2 #(.HOUR_MODE(12), .REPEAT_DELAY(2)) dut12 (
    .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
    .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
    .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6), .d7(b7), .d8(b8));

  assign bus24 = {a8, a7, a6, a5, a4, a3, a2, a1};
  assign bus12 = {b8, b7, b6, b5, b4, b3, b2, b1};
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      act = cur.s12 ? bus12 : bus24;
      n_cmp++;
      if ((act & cur.mask) !== (cur.val & cur.mask)) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (mask %h)", cur.name, act & cur.mask, cur.val & cur.mask, cur.mask);
      end
    end
  end

  function automatic logic [5:0] w(input int c);
    return {1'b0, 4'(c), 1'b0};
  endfunction
  function automatic logic [47:0] cx(input int h, input int m, input int s);
    return {w(h / 10), w(h % 10), SP, w(m / 10), w(m % 10), SP, w(s / 10), w(s % 10)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic press(input int b);
    mode_button = (b == 0 || b == 3);
    add_button = (b == 1 || b == 3);
    sub_button = (b == 2);
    tick();
    {mode_button, add_button, sub_button} = '0;
    tick();
  endtask
  task automatic strobe();
    pulse_1hz = 1;
    tick();
    pulse_1hz = 0;
    tick();
  endtask
  task automatic chk(input string nm, input bit s12, input logic [47:0] m, input logic [47:0] v);
    q.push_back('{nm, s12, m, v});
    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      $display("FAIL %s: monitor did not consume expectation", nm);
      $fatal(1, "monitor stalled");
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_24", 0, FULL, R24);
    chk("reset_12", 1, FULL, R12);
    reset = 0;
    tick();
    repeat (59) strobe();
    chk("run_59s", 0, CM, cx(0, 0, 59));
    strobe();
    chk("run_60s_24", 0, CM | 48'h1, cx(0, 1, 0) | 48'h1);
    chk("run_60s_12", 1, CM | 48'h1, cx(12, 1, 0) | 48'h1);
    press(0);
    press(2);
    chk("set_h_sub_wrap", 0, CM, cx(23, 1, 0));
    chk("set_h_blink_off", 0, ENM, {12'h0, {6{6'b100000}}});
    pulse_500ms = 1;
    tick();
    tick();
    chk("set_h_blink_on", 0, ENM, ENM);
    strobe();
    chk("set_h_frozen", 0, CM, cx(23, 1, 0));
    chk("h12_23_pm", 1, CM | 48'h1, cx(11, 1, 0));
    press(1);
    chk("set_h_add_wrap", 0, CM, cx(0, 1, 0));
    chk("h12_0_am", 1, CM | 48'h1, cx(12, 1, 0) | 48'h1);
    repeat (13) press(1);
    chk("set_h_13", 0, CM, cx(13, 1, 0));
    chk("h12_13_pm", 1, CM | 48'h1, cx(1, 1, 0));
    repeat (10) press(1);
    press(0);
    press(2);
    press(2);
    chk("set_m_sub_wrap", 0, CM, cx(23, 59, 0));
    press(0);
    press(2);
    press(0);
    chk("preset_235959", 0, CM, cx(23, 59, 59));
    strobe();
    chk("rollover_24", 0, CM, cx(0, 0, 0));
    chk("rollover_12", 1, CM | 48'h1, cx(12, 0, 0) | 48'h1);
    pulse_500ms = 0;
    tick();
    press(0);
    press(3);
    chk("mode_add_no_step", 0, CM, cx(0, 0, 0));
    chk("set_m_blink", 0, ENM, {6'b100000, 6'b100000, 6'b100000, 6'b0, 6'b0, 6'b100000, 6'b100000, 6'b100000});
    press(2);
    press(2);
    chk("set_m_58", 0, CM, cx(0, 58, 0));
    add_button = 1;
    tick();
    tick();
    chk("hold_press", 0, CM, cx(0, 59, 0));
    for (int i = 0; i < 4; i++) begin
      pulse_500ms = 1;
      tick();
      tick();
      chk($sformatf("repeat_edge%0d", i + 1), 0, CM, cx(0, rep_exp[i], 0));
      pulse_500ms = 0;
      tick();
      tick();
    end
    sub_button = 1;
    tick();
    pulse_500ms = 1;
    tick();
    tick();
    pulse_500ms = 0;
    tick();
    tick();
    pulse_500ms = 1;
    tick();
    tick();
    chk("add_sub_both", 0, CM, cx(0, 1, 0));
    add_button = 0;
    sub_button = 0;
    tick();
    press(1);
    chk("set_m_add", 0, CM, cx(0, 2, 0));
    press(0);
    add_button = 1;
    tick();
    tick();
    chk("set_s_hold", 0, CM, cx(0, 2, 1));
    pulse_500ms = 0;
    tick();
    pulse_500ms = 1;
    tick();
    #2 reset = 1;
    chk("async_reset_24", 0, FULL, R24);
    chk("async_reset_12", 1, FULL, R12);
    add_button = 0;
    tick();
    tick();
    reset = 0;
    tick();
    strobe();
    chk("post_reset_tick_24", 0, CM | 48'h1, cx(0, 0, 1) | 48'h1);
    chk("post_reset_tick_12", 1, CM | 48'h1, cx(12, 0, 1) | 48'h1);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
